// File: rtl/regbank_pkg.sv
// Shared definitions for the 32x32 MIPS register bank: sizes, register indices
// and the reserved-register decode used by both the write port and the read mux.
package regbank_pkg;

  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_K0   = 5'd26;
  localparam logic [4:0] REG_K1   = 5'd27;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_FP   = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_PEND  = 1'b1
  } buf_state_e;

  function automatic logic is_reserved(input logic [0:AW-1] addr);
    return (addr == REG_AT) || (addr == REG_K0) || (addr == REG_K1);
  endfunction

endpackage

// File: rtl/reg_wr_arb.sv
// Single write-port arbiter: CPU write-back first, DMA through a one-entry buffer.
// Optional DMA starvation guard selected by the DMA_STARVE_EN macro.
module reg_wr_arb #(
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic [0:4]    cpu_waddr,
  input  logic [0:DW-1] cpu_wdata,
  input  logic          dma_valid,
  output logic          dma_ready,
  input  logic [0:4]    dma_waddr,
  input  logic [0:DW-1] dma_wdata,
  output logic          cpu_stall,
  output logic          cpu_blocked,
  output logic          we,
  output logic [0:4]    waddr,
  output logic [0:DW-1] wdata
);
  import regbank_pkg::*;

  buf_state_e    state_r;
  logic [0:4]    baddr_r;
  logic [0:DW-1] bdata_r;
  logic          stall_r;
  logic          cpu_acc_s;
  logic          commit_s;

  assign cpu_acc_s   = cpu_we & ~stall_r;
  assign commit_s    = (state_r == BUF_PEND) & ~cpu_acc_s;
  assign dma_ready   = (state_r == BUF_EMPTY);
  assign cpu_stall   = stall_r;
  assign cpu_blocked = cpu_we & stall_r;

  // DMA holding-buffer FSM; a load and a commit can never share a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BUF_EMPTY;
      baddr_r <= 5'd0;
      bdata_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        BUF_EMPTY: begin
          if (dma_valid) begin
            baddr_r <= dma_waddr;
            bdata_r <= dma_wdata;
            state_r <= BUF_PEND;
          end
        end
        BUF_PEND: begin
          if (commit_s) state_r <= BUF_EMPTY;
        end
        default: state_r <= BUF_EMPTY;
      endcase
    end
  end

`ifdef DMA_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_r;

  // Count blocked PEND cycles; at the limit steal exactly one CPU cycle for the commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      stall_r <= 1'b0;
    end else if ((state_r == BUF_PEND) && cpu_acc_s) begin
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      stall_r <= ((cnt_r + {{(CW-1){1'b0}}, 1'b1}) == CW'(STARVE_MAX));
    end else begin
      cnt_r   <= {CW{1'b0}};
      stall_r <= 1'b0;
    end
  end
`else
  assign stall_r = 1'b0;
`endif

  // Select the one writer that owns the storage port this cycle
  always_comb begin
    we    = 1'b0;
    waddr = 5'd0;
    wdata = {DW{1'b0}};
    if (cpu_acc_s) begin
      we    = 1'b1;
      waddr = cpu_waddr;
      wdata = cpu_wdata;
    end else if (commit_s) begin
      we    = 1'b1;
      waddr = baddr_r;
      wdata = bdata_r;
    end else begin
      we    = 1'b0;
    end
  end

endmodule

// File: rtl/reg_write_port.sv
// Write side of the MIPS register bank: storage, write decode and error pulse.
// Define DMA_STARVE_EN to enable the forced CPU stall for a starved DMA entry.
module reg_write_port #(
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_we,
  input  logic [0:4]       cpu_waddr,
  input  logic [0:DW-1]    cpu_wdata,
  input  logic             dma_valid,
  output logic             dma_ready,
  input  logic [0:4]       dma_waddr,
  input  logic [0:DW-1]    dma_wdata,
  output logic             cpu_stall,
  output logic             wr_err,
  output logic [0:32*DW-1] regs_flat
);
  import regbank_pkg::*;

  logic [0:DW-1] mem_r [NREGS];
  logic          wr_err_r;
  logic          arb_we_s;
  logic [0:4]    arb_addr_s;
  logic [0:DW-1] arb_data_s;
  logic          cpu_blocked_s;

  reg_wr_arb #(.DW(DW), .STARVE_MAX(STARVE_MAX)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_we      (cpu_we),
    .cpu_waddr   (cpu_waddr),
    .cpu_wdata   (cpu_wdata),
    .dma_valid   (dma_valid),
    .dma_ready   (dma_ready),
    .dma_waddr   (dma_waddr),
    .dma_wdata   (dma_wdata),
    .cpu_stall   (cpu_stall),
    .cpu_blocked (cpu_blocked_s),
    .we          (arb_we_s),
    .waddr       (arb_addr_s),
    .wdata       (arb_data_s)
  );

  // Register storage; $zero and reserved registers are never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_r[i] <= {DW{1'b0}};
    end else if (arb_we_s && (arb_addr_s != REG_ZERO) && !is_reserved(arb_addr_s)) begin
      mem_r[arb_addr_s] <= arb_data_s;
    end
  end

  // Error pulse the cycle after a reserved write or a CPU write attempted during stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= (arb_we_s && is_reserved(arb_addr_s)) || cpu_blocked_s;
    end
  end

  assign wr_err = wr_err_r;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*DW +: DW] = is_reserved(5'(g)) ? {DW{1'b0}} : mem_r[g];
  end

endmodule

// File: tb/tb_reg_write_port.sv
// Scoreboard bench for reg_write_port: a register-array model predicts each cycle,
// a negedge monitor compares the DUT against the queued predictions.
module tb_reg_write_port;
  localparam int DW   = 32;
  localparam int SMAX = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cpu_we;
  logic [4:0]       cpu_waddr;
  logic [31:0]      cpu_wdata;
  logic             dma_valid;
  logic             dma_ready;
  logic [4:0]       dma_waddr;
  logic [31:0]      dma_wdata;
  logic             cpu_stall;
  logic             wr_err;
  logic [0:32*DW-1] regs_flat;

  always #5 clk = ~clk;

  reg_write_port #(.DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .dma_valid (dma_valid),
    .dma_ready (dma_ready),
    .dma_waddr (dma_waddr),
    .dma_wdata (dma_wdata),
    .cpu_stall (cpu_stall),
    .wr_err    (wr_err),
    .regs_flat (regs_flat)
  );

  typedef struct packed {
    logic [0:1023] flat;
    logic          rdy;
    logic          stall;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] m_reg [32];
  bit          m_pend;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;
  int          m_blk;
  bit          m_stall;
  bit          m_err;

  logic        dv_h;
  logic [4:0]  da_h;
  logic [31:0] dd_h;

  function automatic bit resv(input logic [4:0] a);
    return (a == 5'd1) || (a == 5'd26) || (a == 5'd27);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flat(input string name, input logic [0:1023] act, input logic [0:1023] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int i = 0; i < 32; i++) begin
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL %s reg%0d: got %h expected %h", name, i, act[i*32 +: 32], exp[i*32 +: 32]);
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pend = 1'b0; m_pa = 5'd0; m_pd = 32'd0; m_blk = 0; m_stall = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge of the architectural model; inputs are what the DUT saw
  task automatic model_edge(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic dv, input logic [4:0] da, input logic [31:0] dd);
    bit acc, commit, err_n, stall_n;
    acc     = we && !m_stall;
    commit  = m_pend && !acc;
    err_n   = (acc && resv(wa)) || (we && m_stall) || (commit && resv(m_pa));
    stall_n = 1'b0;
    if (acc && wa != 5'd0 && !resv(wa)) m_reg[wa] = wd;
    if (commit) begin
      if (m_pa != 5'd0 && !resv(m_pa)) m_reg[m_pa] = m_pd;
      m_pend = 1'b0;
      m_blk  = 0;
    end else if (m_pend) begin
      m_blk++;
`ifdef DMA_STARVE_EN
      stall_n = (m_blk == SMAX);
`endif
    end else if (dv) begin
      m_pend = 1'b1; m_pa = da; m_pd = dd;
    end
    m_stall = stall_n;
    m_err   = err_n;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 32; i++) e.flat[i*32 +: 32] = m_reg[i];
    e.rdy   = !m_pend;
    e.stall = m_stall;
    e.err   = m_err;
    q.push_back(e);
  endtask

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic dv, input logic [4:0] da, input logic [31:0] dd);
    cpu_we = we; cpu_waddr = wa; cpu_wdata = wd;
    dma_valid = dv; dma_waddr = da; dma_wdata = dd;
    @(posedge clk);
    model_edge(we, wa, wd, dv, da, dd);
    push_exp();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_flat({tag, "_regs"}, regs_flat, 1024'd0);
    chk({tag, "_ready"}, {31'd0, dma_ready}, 32'd1);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_err"}, {31'd0, wr_err}, 32'd0);
  endtask

  // Asynchronous reset in the middle of a clock phase
  task automatic mid_reset();
    @(negedge clk);
    #2;
    cpu_we = 1'b0; dma_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    chk("midrst_sb_empty", q.size(), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every negedge compare the DUT against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_flat("regs_flat", regs_flat, e.flat);
        chk("dma_ready", {31'd0, dma_ready}, {31'd0, e.rdy});
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
        chk("wr_err", {31'd0, wr_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cpu_we = 1'b0; cpu_waddr = 5'd0; cpu_wdata = 32'd0;
    dma_valid = 1'b0; dma_waddr = 5'd0; dma_wdata = 32'd0;
    dv_h = 1'b0; da_h = 5'd0; dd_h = 32'd0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    cyc(1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(1);
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 5'd26, 32'h00001234, 1'b0, 5'd0, 32'd0);
    idle(2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hA5A5A5A5);
    idle(3);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h00000001);
    cyc(1'b1, 5'd9, 32'h00000002, 1'b1, 5'd9, 32'h00000001);
    idle(3);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h0BADF00D);
    for (int i = 0; i < 11; i++) cyc(1'b1, 5'd15, 32'(i + 100), 1'b1, 5'd14, 32'h0BADF00D);
    idle(3);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd27, 32'h77777777);
    idle(3);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCAFEF00D);
    cyc(1'b1, 5'd13, 32'h13131313, 1'b1, 5'd12, 32'hCAFEF00D);
    mid_reset();
    idle(3);

    for (int i = 0; i < 600; i++) begin
      logic        we_v;
      logic [4:0]  wa_v;
      if (i == 300) mid_reset();
      if (!m_pend) begin
        dv_h = ($urandom_range(0, 99) < 45);
        da_h = 5'($urandom_range(0, 31));
        dd_h = $urandom;
      end
      we_v = ($urandom_range(0, 99) < 55);
      wa_v = ($urandom_range(0, 3) == 0) ? da_h : 5'($urandom_range(0, 31));
      cyc(we_v, wa_v, $urandom, dv_h, da_h, dd_h);
    end
    idle(8);

    @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
